// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-cycle shift engine.
package shift_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SLL = 2'b01,
        SRA = 2'b10,
        SLA = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Amounts at or beyond the operand width all saturate to a full-width shift.
    function automatic int unsigned clamp_amt(int unsigned amt, int unsigned width);
        return (amt >= width) ? width : amt;
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle between operand source, shift engine and result consumer.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic [1:0]       in_op;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_op, in_signed, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_signed, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-position shifter used once per SHIFT cycle.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  shift_op_t        op,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] next_acc
);

    always_comb begin
        next_acc = acc;
        unique case (op)
            SRL:      next_acc = {1'b0, acc[WIDTH-1:1]};
            SLL, SLA: next_acc = {acc[WIDTH-2:0], 1'b0};
            SRA:      next_acc = {fill_bit, acc[WIDTH-1:1]};
            default:  next_acc = acc;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift engine: accepts an operand, shifts one position per clock, returns the result.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_shifter_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    shift_op_t        op_q, op_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] step_acc;
    logic [AW-1:0]    amt_clamped;
    shift_op_t        in_op_t;

    assign in_op_t     = shift_op_t'(bus.in_op);
    assign amt_clamped = AW'(clamp_amt(32'(bus.in_amt), WIDTH));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .op       (op_q),
        .fill_bit (fill_q),
        .next_acc (step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= SRL;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    op_d    = in_op_t;
                    // Sign fill only matters for a signed arithmetic right shift.
                    fill_d  = bus.in_signed & bus.in_data[WIDTH-1] & (in_op_t == SRA);
                    cnt_d   = amt_clamped;
                    state_d = (amt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - AW'(1);
                end
                if (cnt_q <= AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter at WIDTH=4, AW=3.
module tb_seq_shifter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    seq_shifter_if #(.WIDTH(4), .AW(3)) bus ();

    seq_shifter #(
        .WIDTH (4),
        .AW    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid; lat counts cycles after the accepting edge.
    task automatic wait_out(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!bus.out_valid && l < 20);
    endtask

    task automatic run_op(input string tag, input logic [3:0] data, input logic [2:0] amt,
                          input logic [1:0] op, input logic sgn, input logic [3:0] exp,
                          input int exp_lat);
        int l;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.in_amt    = amt;
        bus.in_op     = op;
        bus.in_signed = sgn;
        bus.out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = ~data;
        bus.in_op    = ~op;
        wait_out(l);
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
        @(negedge clk);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = 2'b00;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function on 1101 by 3, signed.
        run_op("srl3", 4'b1101, 3'd3, 2'b00, 1'b1, 4'b0001, 4);
        run_op("sll3", 4'b1101, 3'd3, 2'b01, 1'b1, 4'b1000, 4);
        run_op("sra3", 4'b1101, 3'd3, 2'b10, 1'b1, 4'b1111, 4);
        run_op("sla3", 4'b1101, 3'd3, 2'b11, 1'b1, 4'b1000, 4);
        run_op("sra_uns", 4'b1101, 3'd3, 2'b10, 1'b0, 4'b0001, 4);
        run_op("sra_pos", 4'b0011, 3'd1, 2'b10, 1'b1, 4'b0001, 2);

        // Zero amount and clamping.
        run_op("zero_srl", 4'b0110, 3'd0, 2'b00, 1'b1, 4'b0110, 1);
        run_op("zero_sll", 4'b0110, 3'd0, 2'b01, 1'b1, 4'b0110, 1);
        run_op("zero_sra", 4'b0110, 3'd0, 2'b10, 1'b1, 4'b0110, 1);
        run_op("zero_sla", 4'b0110, 3'd0, 2'b11, 1'b1, 4'b0110, 1);
        run_op("clamp_srl", 4'b1010, 3'd6, 2'b00, 1'b1, 4'b0000, 5);
        run_op("clamp_sra", 4'b1010, 3'd6, 2'b10, 1'b1, 4'b1111, 5);
        run_op("clamp_sll", 4'b1010, 3'd6, 2'b01, 1'b1, 4'b0000, 5);

        // Reset in the middle of a SHIFT.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1101;
        bus.in_amt   = 3'd3;
        bus.in_op    = 2'b00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 4'b0101, 3'd2, 2'b01, 1'b0, 4'b0100, 3);

        // Backpressure: result held for 10 cycles with out_ready low.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 4'b1101;
        bus.in_amt    = 3'd3;
        bus.in_op     = 2'b01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_data", 32'(bus.out_data), 32'b1000);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back with in_valid held high across two requests.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0001;
        bus.in_amt   = 3'd1;
        bus.in_op    = 2'b01;
        @(posedge clk);
        #1;
        bus.in_data = 4'b1000;
        bus.in_amt  = 3'd2;
        bus.in_op   = 2'b00;
        @(negedge clk);
        check("b2b_first_shift", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_first_data", 32'(bus.out_data), 32'b0010);
        @(negedge clk);
        check("b2b_gap_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_accepted", 32'(bus.busy), 32'd1);
        wait_out(lat);
        check("b2b_second_lat", 32'(lat), 32'd2);
        check("b2b_second_data", 32'(bus.out_data), 32'b0010);
        @(negedge clk);
        check("b2b_done_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
